fo4_ring_monitor: RTL and testbench

//  Delay monitor for the FO4 inverter chain. Gates a ring oscillator built from the

---
 rtl/fo4_ring_monitor.sv | 152 +++++++++++++++
 tb/tb_fo4_ring_monitor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fo4_ring_monitor.sv
// fo4_ring_monitor: counts ring-oscillator rising edges over a clk window.
// Define FO4_MON_MINMAX_EN to add cnt_min/cnt_max tracking outputs.
module fo4_ring_monitor #(
   parameter int CNT_W       = 16,
   parameter int WIN_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE_CYC  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIN_W-1:0] window,
   input  logic             ring_in,
   output logic             ring_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             ovf
`ifdef FO4_MON_MINMAX_EN
   ,
   output logic [CNT_W-1:0] cnt_min,
   output logic [CNT_W-1:0] cnt_max
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      COUNT,
      DONE
   } state_t;

   localparam logic [WIN_W-1:0] ONE_W    = WIN_W'(1);
   localparam logic [WIN_W-1:0] SETTLE_L = WIN_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   state_t                 state_q, state_d;
   logic [WIN_W-1:0]       win_q, win_d;
   logic [WIN_W-1:0]       tmr_q, tmr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   act_q, act_d;
   logic                   done_q, done_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_w;

   assign edge_w = sync_q[SYNC_STAGES-1] & ~prev_q;

   // One timer serves both the settle delay and the measurement window.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               win_d = window;
               cnt_d = '0;
               ovf_d = 1'b0;
               if (window != '0) begin
                  state_d = SETTLE;
                  tmr_d   = SETTLE_L;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SETTLE: begin
            if (tmr_q == ONE_W) begin
               state_d = COUNT;
               tmr_d   = win_q;
            end else begin
               tmr_d = tmr_q - ONE_W;
            end
         end
         COUNT: begin
            if (edge_w) begin
               if (&cnt_q) ovf_d = 1'b1;
               else        cnt_d = cnt_q + ONE_C;
            end
            if (tmr_q == ONE_W) state_d = DONE;
            else                tmr_d   = tmr_q - ONE_W;
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
      act_d  = (state_d == SETTLE) || (state_d == COUNT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         win_q   <= '0;
         tmr_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         act_q   <= 1'b0;
         done_q  <= 1'b0;
         sync_q  <= '0;
         prev_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         act_q   <= act_d;
         done_q  <= done_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], ring_in};
         prev_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign ring_en = act_q;
   assign busy    = act_q;
   assign done    = done_q;
   assign count   = cnt_q;
   assign ovf     = ovf_q;

`ifdef FO4_MON_MINMAX_EN
   logic [CNT_W-1:0] min_q, min_d;
   logic [CNT_W-1:0] max_q, max_d;

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if ((state_q == DONE) && (win_q != '0)) begin
         if (cnt_q < min_q) min_d = cnt_q;
         if (cnt_q > max_q) max_d = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_q <= '1;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign cnt_min = min_q;
   assign cnt_max = max_q;
`endif

endmodule

// File: tb/tb_fo4_ring_monitor.sv
// Directed bench for fo4_ring_monitor with a free-running ring model.
// Build with FO4_MON_MINMAX_EN defined to exercise min/max tracking.
module tb_fo4_ring_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        start4 = 1'b0;
   logic [15:0] window = '0;
   logic        ring_in = 1'b0;
   logic        ring_en, busy, done, ovf;
   logic [15:0] count;
   logic        ring_en4, busy4, done4, ovf4;
   logic [3:0]  count4;
`ifdef FO4_MON_MINMAX_EN
   logic [15:0] cnt_min, cnt_max;
   logic [3:0]  cnt_min4, cnt_max4;
`endif

   int checks = 0;
   int errors = 0;
   int half = 0;
   int ph = 0;
   int lat, en, nd, nb;

   fo4_ring_monitor dut (
      .clk(clk), .rst(rst), .start(start), .window(window),
      .ring_in(ring_in), .ring_en(ring_en), .busy(busy),
      .done(done), .count(count), .ovf(ovf)
`ifdef FO4_MON_MINMAX_EN
      , .cnt_min(cnt_min), .cnt_max(cnt_max)
`endif
   );

   fo4_ring_monitor #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .window(window),
      .ring_in(ring_in), .ring_en(ring_en4), .busy(busy4),
      .done(done4), .count(count4), .ovf(ovf4)
`ifdef FO4_MON_MINMAX_EN
      , .cnt_min(cnt_min4), .cnt_max(cnt_max4)
`endif
   );

   always #5 clk = ~clk;

   // Ring model: toggles every 'half' clk cycles, off the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (half != 0) begin
            ph++;
            if (ph >= half) begin
               ph = 0;
               ring_in = ~ring_in;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse start, then wait (bounded) for done; lat = edges after acceptance.
   task automatic do_run(input bit poke, output int l, output int e);
      start = 1'b1;
      step(1);
      start = 1'b0;
      l = 0;
      e = 0;
      while (done !== 1'b1 && l < 300) begin
         if (ring_en) e++;
         start = poke && (l == 2 || l == 10);
         step(1);
         l++;
      end
      start = 1'b0;
   endtask

   initial begin
      step(3);
      check("rst_ring_en", ring_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", count, 0);
      check("rst_ovf", ovf, 0);
`ifdef FO4_MON_MINMAX_EN
      check("rst_min", cnt_min, 16'hffff);
      check("rst_max", cnt_max, 0);
`endif
      rst = 1'b0;
      half = 4;
      step(20);

      // Normal run: period 8, window 64.
      window = 16'd64;
      do_run(1'b0, lat, en);
      check("t1_latency", lat, 68);
      check("t1_ring_en_cycles", en, 68);
      check("t1_count", count, 8);
      check("t1_ovf", ovf, 0);
      check("t1_busy_in_done", busy, 0);
      step(1);
      check("t1_done_single", done, 0);
      step(5);
      check("t1_count_held", count, 8);

      // Zero window.
      window = 16'd0;
      do_run(1'b0, lat, en);
      check("t2_latency", lat, 0);
      check("t2_ring_en_cycles", en, 0);
      check("t2_ring_en", ring_en, 0);
      check("t2_count", count, 0);
      step(1);
      check("t2_done_single", done, 0);

      // Starts while busy are ignored; window change mid-run ignored.
      window = 16'd32;
      step(5);
      start = 1'b1;
      step(1);
      start = 1'b0;
      window = 16'd200;
      lat = 0;
      while (done !== 1'b1 && lat < 300) begin
         start = (lat == 2 || lat == 10);
         step(1);
         lat++;
      end
      start = 1'b0;
      check("t3_latency", lat, 36);
      check("t3_count", count, 4);
      nd = 0;
      nb = 0;
      repeat (80) begin
         step(1);
         if (done) nd++;
         if (busy) nb++;
      end
      check("t3_no_second_done", nd, 0);
      check("t3_no_second_busy", nb, 0);

      // Saturation on the 4-bit instance: rising edge every 2 clk.
      half = 1;
      window = 16'd40;
      step(20);
      start4 = 1'b1;
      step(1);
      start4 = 1'b0;
      lat = 0;
      while (done4 !== 1'b1 && lat < 300) begin
         step(1);
         lat++;
      end
      check("t4_latency", lat, 44);
      check("t4_count", count4, 15);
      check("t4_ovf", ovf4, 1);

      // Reset in the middle of COUNT.
      half = 4;
      window = 16'd64;
      step(20);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(20);
      check("t5_busy_before_rst", busy, 1);
      rst = 1'b1;
      #1;
      check("t5_rst_ring_en", ring_en, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_done", done, 0);
      check("t5_rst_count", count, 0);
      check("t5_rst_ovf", ovf, 0);
      step(2);
      rst = 1'b0;
      nd = 0;
      repeat (80) begin
         step(1);
         if (done) nd++;
      end
      check("t5_no_done", nd, 0);
      do_run(1'b0, lat, en);
      check("t5_rerun_latency", lat, 68);
      check("t5_rerun_count", count, 8);
      check("t5_rerun_ovf", ovf, 0);

`ifdef FO4_MON_MINMAX_EN
      half = 4;
      step(20);
      do_run(1'b0, lat, en);
      check("t6_count_p8", count, 8);
      half = 2;
      step(20);
      do_run(1'b0, lat, en);
      check("t6_count_p4", count, 16);
      half = 8;
      step(20);
      do_run(1'b0, lat, en);
      check("t6_count_p16", count, 4);
      step(1);
      check("t6_min", cnt_min, 4);
      check("t6_max", cnt_max, 16);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
